// File: rtl/dead_time_gen_pkg.sv
// Shared definitions for the dead-time generator: leg state encoding and default widths.
package dead_time_gen_pkg;

    localparam int unsigned DT_W_DEF    = 8;
    localparam int unsigned SWCNT_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_DEAD = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } leg_state_t;

endpackage

// File: rtl/dead_time_gen_if.sv
// Command/gate bundle between the regularization stage and the gate-driver pins.
interface dead_time_gen_if
    import dead_time_gen_pkg::*;
#(
    parameter int unsigned N       = 1,
    parameter int unsigned DT_W    = DT_W_DEF,
    parameter int unsigned SWCNT_W = SWCNT_W_DEF
);
    logic                 i_enable;
    logic [N-1:0]         i_sigma;
    logic [DT_W-1:0]      i_dead_time;
    logic                 i_fault;
    logic                 i_fault_clear;
    logic [N-1:0]         o_hs;
    logic [N-1:0]         o_ls;
    logic [N-1:0]         o_dead;
    logic                 o_fault;
    logic [N*SWCNT_W-1:0] o_sw_count;

    modport master (
        output i_enable, i_sigma, i_dead_time, i_fault, i_fault_clear,
        input  o_hs, o_ls, o_dead, o_fault, o_sw_count
    );

    modport slave (
        input  i_enable, i_sigma, i_dead_time, i_fault, i_fault_clear,
        output o_hs, o_ls, o_dead, o_fault, o_sw_count
    );
endinterface

// File: rtl/dead_time_core.sv
// One bridge leg: OFF/DEAD/HIGH/LOW sequencer with dead-time countdown and
// switching-event counter; gate outputs are registered from the next state.
module dead_time_core
    import dead_time_gen_pkg::*;
#(
    parameter int unsigned DT_W    = DT_W_DEF,
    parameter int unsigned SWCNT_W = SWCNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               sigma,
    input  logic [DT_W-1:0]    dead_time,
    output logic               hs,
    output logic               ls,
    output logic               dead,
    output logic [SWCNT_W-1:0] sw_count
);

    leg_state_t      state;
    leg_state_t      state_nxt;
    logic [DT_W-1:0] cnt;
    logic [DT_W-1:0] cnt_nxt;
    logic [DT_W-1:0] cnt_load;
    logic            sw_inc;

    // Zero dead time is treated as one cycle, so the load value is D-1 with D>=1.
    assign cnt_load = (dead_time == DT_W'(0)) ? DT_W'(0) : dead_time - DT_W'(1);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sw_inc    = 1'b0;
        case (state)
            ST_OFF: begin
                if (run) begin
                    state_nxt = ST_DEAD;
                    cnt_nxt   = cnt_load;
                end
            end
            ST_HIGH: begin
                if (!run) begin
                    state_nxt = ST_OFF;
                end else if (!sigma) begin
                    state_nxt = ST_DEAD;
                    cnt_nxt   = cnt_load;
                end
            end
            ST_LOW: begin
                if (!run) begin
                    state_nxt = ST_OFF;
                end else if (sigma) begin
                    state_nxt = ST_DEAD;
                    cnt_nxt   = cnt_load;
                end
            end
            ST_DEAD: begin
                if (!run) begin
                    state_nxt = ST_OFF;
                end else if (cnt == DT_W'(0)) begin
                    state_nxt = sigma ? ST_HIGH : ST_LOW;
                    sw_inc    = 1'b1;
                end else begin
                    cnt_nxt = cnt - DT_W'(1);
                end
            end
            default: state_nxt = ST_OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_OFF;
            cnt      <= DT_W'(0);
            hs       <= 1'b0;
            ls       <= 1'b0;
            dead     <= 1'b0;
            sw_count <= SWCNT_W'(0);
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            hs    <= (state_nxt == ST_HIGH);
            ls    <= (state_nxt == ST_LOW);
            dead  <= (state_nxt == ST_DEAD);
            if (sw_inc) begin
                sw_count <= sw_count + SWCNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/dead_time_gen.sv
// N-leg complementary gate generator with shared dead time, enable and a
// latched fault shutdown; each leg is an independent dead_time_core.
module dead_time_gen
    import dead_time_gen_pkg::*;
#(
    parameter int unsigned N       = 1,
    parameter int unsigned DT_W    = DT_W_DEF,
    parameter int unsigned SWCNT_W = SWCNT_W_DEF
) (
    input  logic           i_clk,
    input  logic           i_reset,
    dead_time_gen_if.slave bus
);

    logic fault_latched;
    logic run;

    // Fault set has priority over clear; clear is honoured only once the fault input drops.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            fault_latched <= 1'b0;
        end else if (bus.i_fault) begin
            fault_latched <= 1'b1;
        end else if (bus.i_fault_clear) begin
            fault_latched <= 1'b0;
        end
    end

    assign bus.o_fault = fault_latched;
    assign run         = bus.i_enable & ~fault_latched;

    for (genvar g = 0; g < int'(N); g++) begin : g_leg
        dead_time_core #(
            .DT_W    (DT_W),
            .SWCNT_W (SWCNT_W)
        ) u_core (
            .clk       (i_clk),
            .reset     (i_reset),
            .run       (run),
            .sigma     (bus.i_sigma[g]),
            .dead_time (bus.i_dead_time),
            .hs        (bus.o_hs[g]),
            .ls        (bus.o_ls[g]),
            .dead      (bus.o_dead[g]),
            .sw_count  (bus.o_sw_count[g*SWCNT_W +: SWCNT_W])
        );
    end

endmodule
